// File: rtl/reg_write_bank.sv
// Write side of the 32-entry register file: decoded single-port write plus a
// one-register-per-cycle bank clear sequence, all outputs registered.
module reg_write_bank #(
  parameter int N        = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [N-1:0]    wr_data,
  input  logic            clr_req,
  output logic            wr_ack,
  output logic            busy,
  output logic            clr_done,
  output logic [32*N-1:0] regs_flat
);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                state_q;
  logic [4:0]            clrIdx_q;
  logic [31:0][N-1:0]    regs_q, regs_d;
  logic                  wrAck_q, busy_q, clrDone_q;

  // Bank next value: clear walk wins over writes, and a clear request in IDLE
  // swallows any simultaneous write. Hardwired reg 0 never takes a value.
  always_comb begin
    regs_d = regs_q;
    if (state_q == CLEAR) begin
      regs_d[clrIdx_q] = '0;
    end else if (wr_en && !clr_req) begin
      regs_d[wr_addr] = wr_data;
    end
    if (ZERO_REG) begin
      regs_d[0] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clrIdx_q  <= '0;
      regs_q    <= '0;
      wrAck_q   <= 1'b0;
      busy_q    <= 1'b0;
      clrDone_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      wrAck_q   <= 1'b0;
      clrDone_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q  <= CLEAR;
            clrIdx_q <= '0;
            busy_q   <= 1'b1;
          end else if (wr_en) begin
            wrAck_q <= 1'b1;
          end
        end
        CLEAR: begin
          // Index wraps naturally to 0 after the last register
          clrIdx_q <= clrIdx_q + 5'd1;
          if (clrIdx_q == 5'd31) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            clrDone_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_ack    = wrAck_q;
  assign busy      = busy_q;
  assign clr_done  = clrDone_q;
  assign regs_flat = regs_q;

endmodule
